// File: rtl/prog_div_pkg.sv
// prog_div_pkg: shared constants and helpers for the programmable clock divider.
package prog_div_pkg;
    localparam int DIV_CNT_W_MAX = 16;
    localparam int DIV_MIN_NUM   = 2;

    function automatic int chw(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction
endpackage

// File: rtl/prog_div_chan.sv
// prog_div_chan: one divider channel with active/shadow ratio+duty and boundary-aligned apply.
module prog_div_chan
    import prog_div_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int DEF_NUM  = 4,
    parameter int DEF_DUTY = 2
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic             en_sig,
    input  logic             load_sig,
    input  logic [CNT_W-1:0] ld_num_sig,
    input  logic [CNT_W-1:0] ld_duty_sig,
    output logic             pend_sig,
    output logic             div_sig,
    output logic             tick_sig
);
    logic [CNT_W-1:0] cnt_q, cnt_d, num_q, num_d, duty_q, duty_d, sh_num_q, sh_num_d, sh_duty_q, sh_duty_d;
    logic             pend_q, pend_d, div_q, div_d, tick_q, tick_d, wrap, apply;

    // A pending setting waits for the wrap edge so the new period starts at cnt 0.
    always_comb begin
        wrap      = cnt_q == num_q - CNT_W'(1);
        apply     = pend_q & (!en_sig | wrap);
        cnt_d     = (en_sig & !wrap) ? cnt_q + CNT_W'(1) : '0;
        div_d     = en_sig & (cnt_q < duty_q);
        tick_d    = en_sig & (cnt_q == '0);
        num_d     = apply ? sh_num_q : num_q;
        duty_d    = apply ? sh_duty_q : duty_q;
        pend_d    = load_sig | (pend_q & !apply);
        sh_num_d  = load_sig ? ld_num_sig : sh_num_q;
        sh_duty_d = load_sig ? ld_duty_sig : sh_duty_q;
    end

    always_ff @(posedge clk_sig) begin
        if (!reset_sig) begin
            cnt_q     <= '0;
            num_q     <= CNT_W'(DEF_NUM);
            duty_q    <= CNT_W'(DEF_DUTY);
            sh_num_q  <= CNT_W'(DEF_NUM);
            sh_duty_q <= CNT_W'(DEF_DUTY);
            pend_q    <= 1'b0;
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            duty_q    <= duty_d;
            sh_num_q  <= sh_num_d;
            sh_duty_q <= sh_duty_d;
            pend_q    <= pend_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
        end
    end

    assign pend_sig = pend_q;
    assign div_sig  = div_q;
    assign tick_sig = tick_q;
endmodule

// File: rtl/prog_div.sv
// prog_div: CH-channel runtime-programmable clock divider with a valid/ready config port.
module prog_div
    import prog_div_pkg::*;
#(
    parameter  int CH       = 2,
    parameter  int CNT_W    = 8,
    parameter  int DEF_NUM  = 4,
    parameter  int DEF_DUTY = 2,
    localparam int CHW      = chw(CH)
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic [CH-1:0]    en_sig,
    input  logic             cfg_valid_sig,
    output logic             cfg_ready_sig,
    input  logic [CHW-1:0]   cfg_ch_sig,
    input  logic [CNT_W-1:0] cfg_num_sig,
    input  logic [CNT_W-1:0] cfg_duty_sig,
    output logic             cfg_err_sig,
    output logic [CH-1:0]    div_sig,
    output logic [CH-1:0]    tick_sig
);
    localparam int NP = 2 ** CHW;

    logic [CH-1:0] pend;
    logic [NP-1:0] pend_pad;
    logic          fire, legal, err_d, err_q;

    // Out-of-range channels index zero padding, so they always look ready and get rejected.
    always_comb begin
        pend_pad      = NP'(pend);
        cfg_ready_sig = !pend_pad[cfg_ch_sig];
        fire          = cfg_valid_sig & cfg_ready_sig;
        legal         = (int'(cfg_ch_sig) < CH) & (cfg_num_sig >= CNT_W'(DIV_MIN_NUM)) &
                        (cfg_duty_sig <= cfg_num_sig);
        err_d         = fire & !legal;
    end

    always_ff @(posedge clk_sig) begin
        if (!reset_sig) err_q <= 1'b0;
        else            err_q <= err_d;
    end

    assign cfg_err_sig = err_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        prog_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_NUM (DEF_NUM),
            .DEF_DUTY(DEF_DUTY)
        ) u_chan (
            .clk_sig    (clk_sig),
            .reset_sig  (reset_sig),
            .en_sig     (en_sig[i]),
            .load_sig   (fire & legal & (cfg_ch_sig == CHW'(i))),
            .ld_num_sig (cfg_num_sig),
            .ld_duty_sig(cfg_duty_sig),
            .pend_sig   (pend[i]),
            .div_sig    (div_sig[i]),
            .tick_sig   (tick_sig[i])
        );
    end
endmodule

// File: tb/tb_prog_div.sv
// tb_prog_div: randomized config/enable/reset traffic checked against a period-phase reference model.
module tb_prog_div;
    localparam int CH    = 3;
    localparam int CNT_W = 8;
    localparam int CHW   = 2;

    logic             clk_sig = 1'b0;
    logic             reset_sig;
    logic [CH-1:0]    en_sig;
    logic             cfg_valid_sig;
    logic             cfg_ready_sig;
    logic [CHW-1:0]   cfg_ch_sig;
    logic [CNT_W-1:0] cfg_num_sig;
    logic [CNT_W-1:0] cfg_duty_sig;
    logic             cfg_err_sig;
    logic [CH-1:0]    div_sig;
    logic [CH-1:0]    tick_sig;

    prog_div #(.CH(CH), .CNT_W(CNT_W), .DEF_NUM(4), .DEF_DUTY(2)) dut (
        .clk_sig      (clk_sig),
        .reset_sig    (reset_sig),
        .en_sig       (en_sig),
        .cfg_valid_sig(cfg_valid_sig),
        .cfg_ready_sig(cfg_ready_sig),
        .cfg_ch_sig   (cfg_ch_sig),
        .cfg_num_sig  (cfg_num_sig),
        .cfg_duty_sig (cfg_duty_sig),
        .cfg_err_sig  (cfg_err_sig),
        .div_sig      (div_sig),
        .tick_sig     (tick_sig)
    );

    always #5 clk_sig = ~clk_sig;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    endtask

    // Model: position within the current period, active ratio/duty, and at most one queued setting.
    int ph[CH], mn[CH], md[CH], pn[CH], pd[CH];
    bit pv[CH];
    int e_div, e_tick, e_err;

    function automatic bit model_ready(input int ch);
        return (ch >= CH) ? 1'b1 : !pv[ch];
    endfunction

    task automatic model_step;
        int  ch, num, duty;
        bit  fire, legal, app;
        ch    = int'(cfg_ch_sig);
        num   = int'(cfg_num_sig);
        duty  = int'(cfg_duty_sig);
        e_div = 0;
        e_tick = 0;
        if (!reset_sig) begin
            for (int i = 0; i < CH; i++) begin
                ph[i] = 0; mn[i] = 4; md[i] = 2; pv[i] = 0;
            end
            e_err = 0;
            return;
        end
        fire  = cfg_valid_sig && model_ready(ch);
        legal = (ch < CH) && (num >= 2) && (duty <= num);
        e_err = int'(fire && !legal);
        for (int i = 0; i < CH; i++) begin
            app = pv[i] && (!en_sig[i] || ph[i] == mn[i] - 1);
            if (en_sig[i]) begin
                e_div  |= int'(ph[i] < md[i]) << i;
                e_tick |= int'(ph[i] == 0) << i;
                ph[i]  = (ph[i] + 1) % mn[i];
            end else begin
                ph[i] = 0;
            end
            if (app) begin
                mn[i] = pn[i]; md[i] = pd[i]; pv[i] = 0;
            end
        end
        if (fire && legal) begin
            pv[ch] = 1; pn[ch] = num; pd[ch] = duty;
        end
    endtask

    task automatic cycle;
        #2;
        check("ready", int'(cfg_ready_sig), int'(model_ready(int'(cfg_ch_sig))));
        model_step();
        @(posedge clk_sig);
        #1;
        check("div", int'(div_sig), e_div);
        check("tick", int'(tick_sig), e_tick);
        check("err", int'(cfg_err_sig), e_err);
    endtask

    task automatic randomize_inputs;
        int n;
        reset_sig = ($urandom_range(0, 299) != 0);
        for (int i = 0; i < CH; i++)
            if ($urandom_range(0, 24) == 0) en_sig[i] = ~en_sig[i];
        cfg_valid_sig = ($urandom_range(0, 2) == 0);
        cfg_ch_sig    = CHW'($urandom_range(0, 3));
        n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 8));
        cfg_num_sig  = CNT_W'(n);
        cfg_duty_sig = CNT_W'((n >= 255) ? $urandom_range(0, 255) : $urandom_range(0, n + 1));
    endtask

    initial begin
        reset_sig     = 1'b0;
        en_sig        = '0;
        cfg_valid_sig = 1'b0;
        cfg_ch_sig    = '0;
        cfg_num_sig   = '0;
        cfg_duty_sig  = '0;
        repeat (2) cycle();
        reset_sig = 1'b1;
        en_sig    = '1;
        repeat (12) cycle();
        // Hold a legal request on ch1 for several cycles to exercise back-pressure.
        cfg_valid_sig = 1'b1;
        cfg_ch_sig    = 2'd1;
        cfg_num_sig   = 8'd6;
        cfg_duty_sig  = 8'd3;
        repeat (2) cycle();
        cfg_num_sig  = 8'd5;
        cfg_duty_sig = 8'd5;
        repeat (8) cycle();
        cfg_valid_sig = 1'b0;
        repeat (12) cycle();
        repeat (4000) begin
            randomize_inputs();
            cycle();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
